// File: rtl/vs4x400_axi_loader.sv
// AXI4-Lite write initiator for the vs4x400 search core.
// Turns (row, 64-bit entry) loads and start requests into ordered register writes.
module vs4x400_axi_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [9:0]  ld_addr,
  input  logic [63:0] ld_data,
  input  logic        go,
  input  logic        err_clr,
  output logic        busy,
  output logic        err,
  output logic [10:0] load_count,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam logic [31:0] OFS_CTRL   = 32'h0000_0000;
  localparam logic [31:0] OFS_DLO    = 32'h0000_0010;
  localparam logic [31:0] OFS_DHI    = 32'h0000_0014;
  localparam logic [31:0] OFS_ROW    = 32'h0000_0018;
  localparam logic [31:0] CTRL_START = 32'h0000_0001;
  localparam logic [31:0] CTRL_WE    = 32'h0000_0002;
  localparam logic [10:0] CNT_MAX    = 11'h7FF;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
  typedef enum logic {M_LOAD, M_START} mode_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [1:0]  beat_q, beat_d;
  logic [63:0] data_q, data_d;
  logic [9:0]  row_q, row_d;
  logic        go_pend_q, go_pend_d;
  logic        err_q, err_d;
  logic [10:0] cnt_q, cnt_d;
  logic        ld_ready_q, ld_ready_d;
  logic        busy_q, busy_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  beat_t       word;

  // Address/data pair for one write of the current sequence.
  function automatic beat_t beat_word(input mode_e mode, input logic [1:0] beat,
                                      input logic [63:0] data, input logic [9:0] row);
    beat_t w;
    w.addr = BASE_ADDR + OFS_CTRL;
    w.data = CTRL_START;
    if (mode == M_LOAD) begin
      case (beat)
        2'd0:    begin w.addr = BASE_ADDR + OFS_DLO;  w.data = data[31:0];     end
        2'd1:    begin w.addr = BASE_ADDR + OFS_DHI;  w.data = data[63:32];    end
        2'd2:    begin w.addr = BASE_ADDR + OFS_ROW;  w.data = {22'b0, row};   end
        default: begin w.addr = BASE_ADDR + OFS_CTRL; w.data = CTRL_WE;       end
      endcase
    end
    return w;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path
    // leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    beat_d    = beat_q;
    data_d    = data_q;
    row_d     = row_q;
    go_pend_d = go_pend_q | go;
    err_d     = err_clr ? 1'b0 : err_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    word      = '{addr: awaddr_q, data: wdata_q};

    case (state_q)
      S_IDLE: begin
        if (ld_valid && ld_ready_q) begin
          data_d    = ld_data;
          row_d     = ld_addr;
          mode_d    = M_LOAD;
          beat_d    = 2'd0;
          state_d   = S_ISSUE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          word      = beat_word(M_LOAD, 2'd0, ld_data, ld_addr);
        end else if (go_pend_q) begin
          mode_d    = M_START;
          beat_d    = 2'd0;
          state_d   = S_ISSUE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          word      = beat_word(M_START, 2'd0, data_q, row_q);
        end
      end

      S_ISSUE: begin
        // Address and data channels complete independently, in either order.
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_RESP;
          bready_d = 1'b1;
        end
      end

      S_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          if (mode_q == M_LOAD && beat_q != 2'd3) begin
            beat_d    = beat_q + 2'd1;
            state_d   = S_ISSUE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            word      = beat_word(M_LOAD, beat_q + 2'd1, data_q, row_q);
          end else if (mode_q == M_LOAD) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
            state_d = S_IDLE;
          end else begin
            cnt_d     = '0;
            go_pend_d = go;
            state_d   = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    awaddr_d   = word.addr;
    wdata_d    = word.data;
    ld_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE) || go_pend_d;
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q    <= S_IDLE;
      mode_q     <= M_LOAD;
      beat_q     <= 2'd0;
      // NOTE: the captured entry is reset too, so an abandoned load leaves no
      // stale payload behind.
      data_q     <= '0;
      row_q      <= '0;
      go_pend_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      mode_q     <= mode_d;
      beat_q     <= beat_d;
      data_q     <= data_d;
      row_q      <= row_d;
      go_pend_q  <= go_pend_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
    end
  end

  assign ld_ready      = ld_ready_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign load_count    = cnt_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_vs4x400_axi_loader.sv
// Directed bench for vs4x400_axi_loader: a small AXI-Lite slave with programmable
// ready delays and error injection, a write log, and hand-computed expectations.
module tb_vs4x400_axi_loader;

  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [9:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;
  logic        go = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        err;
  logic [10:0] load_count;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Slave model state
  wr_t         wlog[$];
  int          aw_len_q[$];
  int          w_len_q[$];
  int          aw_dly = 1;
  int          w_dly  = 1;
  logic [31:0] bad_addr = '1;
  int          stab_err = 0;
  int          b_cyc = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  logic        aw_hold_v = 1'b0, w_hold_v = 1'b0;
  logic [31:0] aw_hold = '0, w_hold = '0;
  int          aw_cnt = 0, w_cnt = 0;
  wr_t         cur = '0;

  vs4x400_axi_loader #(.BASE_ADDR(BASE)) u_dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .go            (go),
    .err_clr       (err_clr),
    .busy          (busy),
    .err           (err),
    .load_count    (load_count),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: observe handshakes on the pre-edge values, then drive readies 1 ns later.
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0;
      aw_cnt = 0; w_cnt = 0; aw_hold_v = 1'b0; w_hold_v = 1'b0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend = 1'b0;
        b_cyc  = cyc;
      end
      if (m_axi_awvalid) begin
        if (aw_hold_v && m_axi_awaddr !== aw_hold) stab_err++;
        if (m_axi_awready) begin
          aw_got = 1'b1; cur.addr = m_axi_awaddr;
          aw_len_q.push_back(aw_cnt + 1);
          aw_cnt = 0; aw_hold_v = 1'b0;
        end else begin
          aw_cnt++; aw_hold = m_axi_awaddr; aw_hold_v = 1'b1;
        end
      end
      if (m_axi_wvalid) begin
        if (w_hold_v && m_axi_wdata !== w_hold) stab_err++;
        if (m_axi_wready) begin
          w_got = 1'b1; cur.data = m_axi_wdata;
          w_len_q.push_back(w_cnt + 1);
          w_cnt = 0; w_hold_v = 1'b0;
        end else begin
          w_cnt++; w_hold = m_axi_wdata; w_hold_v = 1'b1;
        end
      end
      if (aw_got && w_got) begin
        wlog.push_back(cur);
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
      end
    end
    cyc++;
    #1;
    m_axi_awready = rst_n && m_axi_awvalid && (aw_cnt + 1 >= aw_dly);
    m_axi_wready  = rst_n && m_axi_wvalid && (w_cnt + 1 >= w_dly);
    m_axi_bvalid  = b_pend;
    m_axi_bresp   = (b_pend && cur.addr == bad_addr) ? 2'b10 : 2'b00;
  end

  task automatic send_entry(input logic [9:0] a, input logic [63:0] d, output int acc);
    int n;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    n = 0;
    while (!ld_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) check("accept_timeout", ld_ready, 1);
    acc = cyc;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic wait_ready(output int at);
    int n;
    n = 0;
    while (!ld_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) check("ready_timeout", ld_ready, 1);
    at = cyc;
  endtask

  task automatic wait_idle(output int at);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
    at = cyc;
  endtask

  task automatic check_writes(input string name, input logic [9:0] row, input logic [63:0] d);
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{BASE + 32'h10, BASE + 32'h14, BASE + 32'h18, BASE};
    ed = '{d[31:0], d[63:32], {22'b0, row}, 32'h2};
    check({name, "_nwr"}, wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog.size()) begin
        check($sformatf("%s_addr%0d", name, i), wlog[i].addr, ea[i]);
        check($sformatf("%s_data%0d", name, i), wlog[i].data, ed[i]);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, rdy, idle_at, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", {ld_ready, busy, err, load_count, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_wdata", m_axi_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ld_ready_first_edge", ld_ready, 1);

    // One entry, always-ready slave
    wlog.delete();
    send_entry(10'h005, 64'h1122_3344_5566_7788, acc);
    check("t1_valids_n1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    check("t1_awaddr_n1", m_axi_awaddr, 32'h4000_0010);
    check("t1_ld_ready_low", ld_ready, 0);
    wait_ready(rdy);
    check("t1_ready_lat", rdy - acc, 9);
    check("t1_nwr", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("t1_w0", wlog[0], {32'h4000_0010, 32'h5566_7788});
      check("t1_w1", wlog[1], {32'h4000_0014, 32'h1122_3344});
      check("t1_w2", wlog[2], {32'h4000_0018, 32'h0000_0005});
      check("t1_w3", wlog[3], {32'h4000_0000, 32'h0000_0002});
    end
    check("t1_count", load_count, 1);

    // Slow slave: awready after 3 cycles, wready immediately
    aw_dly = 3; wlog.delete(); aw_len_q.delete(); w_len_q.delete(); stab_err = 0;
    send_entry(10'h03A, 64'hDEAD_BEEF_0BAD_F00D, acc);
    wait_ready(rdy);
    check_writes("t2", 10'h03A, 64'hDEAD_BEEF_0BAD_F00D);
    check("t2_aw_beats", aw_len_q.size(), 4);
    check("t2_w_beats", w_len_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < aw_len_q.size()) check($sformatf("t2_awlen%0d", i), aw_len_q[i], 3);
      if (i < w_len_q.size())  check($sformatf("t2_wlen%0d", i), w_len_q[i], 1);
    end
    check("t2_stable", stab_err, 0);
    check("t2_count", load_count, 2);
    aw_dly = 1;

    // Two go pulses during a load collapse into one start after the entry
    wlog.delete();
    send_entry(10'h100, 64'h0123_4567_89AB_CDEF, acc);
    go = 1'b1; @(negedge clk); go = 1'b0;
    repeat (2) @(negedge clk);
    go = 1'b1; @(negedge clk); go = 1'b0;
    wait_ready(rdy);
    check("t3_ready_lat", rdy - acc, 9);
    check("t3_count_pre", load_count, 3);
    check("t3_busy_pre", busy, 1);
    wait_idle(idle_at);
    check("t3_busy_fall", idle_at - b_cyc, 1);
    check("t3_count_clr", load_count, 0);
    repeat (5) @(negedge clk);
    check("t3_nwr", wlog.size(), 5);
    if (wlog.size() == 5) begin
      check("t3_we", wlog[3], {32'h4000_0000, 32'h0000_0002});
      check("t3_start", wlog[4], {32'h4000_0000, 32'h0000_0001});
    end

    // Error response on the data-high beat
    check("t4_err_init", err, 0);
    bad_addr = BASE + 32'h14; wlog.delete();
    send_entry(10'h2C1, 64'hA5A5_0000_FFFF_5A5A, acc);
    wait_ready(rdy);
    bad_addr = '1;
    check("t4_err_set", err, 1);
    check_writes("t4", 10'h2C1, 64'hA5A5_0000_FFFF_5A5A);
    check("t4_count", load_count, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("t4_err_clr", err, 0);

    // Reset while the row-address beat is waiting for awready
    aw_dly = 2; wlog.delete();
    send_entry(10'h077, 64'h0F0F_0F0F_F0F0_F0F0, acc);
    go = 1'b1; @(negedge clk); go = 1'b0;
    n = 0;
    while (!(m_axi_awvalid && m_axi_awaddr == BASE + 32'h18) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_beat2_valid", m_axi_awvalid, 1);
    check("t5_beat2_addr", m_axi_awaddr, 32'h4000_0018);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {ld_ready, busy, err, load_count, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check("t5_rst_awaddr", m_axi_awaddr, 0);
    check("t5_rst_wdata", m_axi_wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; aw_dly = 1; wlog.delete();
    repeat (3) @(negedge clk);
    check("t5_go_dropped", busy, 0);
    check("t5_no_writes", wlog.size(), 0);
    send_entry(10'h3FF, 64'hCAFE_F00D_1234_5678, acc);
    wait_ready(rdy);
    check_writes("t5", 10'h3FF, 64'hCAFE_F00D_1234_5678);
    check("t5_count", load_count, 1);

    // Counter saturation without any start
    for (int i = 0; i < 2045; i++) begin
      send_entry(i[9:0], {32'(i), ~32'(i)}, acc);
      wlog.delete(); aw_len_q.delete(); w_len_q.delete();
    end
    wait_ready(rdy);
    check("t6_count_7fe", load_count, 11'h7FE);
    send_entry(10'h001, 64'h1, acc);
    wait_ready(rdy);
    check("t6_count_7ff", load_count, 11'h7FF);
    for (int i = 0; i < 2; i++) begin
      send_entry(10'h002, 64'h2, acc);
      wlog.delete();
    end
    wait_ready(rdy);
    check("t6_count_sat", load_count, 11'h7FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
